// File: rtl/trng_pkg.sv
// trng_pkg: shared types and default configuration for the TRNG sequencing controller.
package trng_pkg;

   // Controller FSM states, also exported on the debug state port.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_HOLD   = 2'd3
   } trng_ctrl_state_t;

   localparam int TRNG_WORD_WIDTH    = 32;
   localparam int TRNG_WARMUP_CYCLES = 256;
   localparam int TRNG_SAMPLE_DIV    = 4;
   localparam int TRNG_RC_LIMIT      = 16;

endpackage

// File: rtl/trng_ctrl_if.sv
// trng_ctrl_if: word output channel of the TRNG controller.
// Handshake: a word transfers on every rising clk edge where valid_o & ready_i
// are both high; once valid_o rises it stays high with data_o unchanged until
// that transfer (only reset may drop it), and ready_i may be driven freely.
interface trng_ctrl_if
   import trng_pkg::*;
#(
   parameter int WORD_WIDTH = TRNG_WORD_WIDTH
);
   logic [WORD_WIDTH-1:0] data_o;
   logic                  valid_o;
   logic                  ready_i;

   modport master (output data_o, output valid_o, input ready_i);
   modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/trng_sync.sv
// trng_sync: 2-flop synchronizer with synchronous active-high reset for an
// asynchronous single-bit input.
module trng_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic meta_q;
   logic sync_q;

   // Two-stage capture; only the second stage is consumed downstream.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;
endmodule

// File: rtl/trng_ctrl.sv
// trng_ctrl: sequences the ring-oscillator TRNG core (warm-up, divided-rate
// sampling, word packing) and offers each word on a valid/ready channel.
// Optional repetition-count health test is built when TRNG_HEALTH_EN is defined.
module trng_ctrl
   import trng_pkg::*;
#(
   parameter int WORD_WIDTH    = TRNG_WORD_WIDTH,
   parameter int WARMUP_CYCLES = TRNG_WARMUP_CYCLES,
   parameter int SAMPLE_DIV    = TRNG_SAMPLE_DIV,
   parameter int RC_LIMIT      = TRNG_RC_LIMIT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic             trng_en,
   input  logic             trng_in,
   output logic             busy_o,
   output logic             health_fail_o,
   output trng_ctrl_state_t state_o,
   trng_ctrl_if.master      bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WARMUP = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_HOLD   = 2'd3;

   localparam int WCW = $clog2(WARMUP_CYCLES) + 1;
   localparam int DCW = $clog2(SAMPLE_DIV) + 1;
   localparam int BCW = $clog2(WORD_WIDTH) + 1;

   localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_CYCLES - 1);
   localparam logic [DCW-1:0] DIV_LAST  = DCW'(SAMPLE_DIV - 1);
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_WIDTH - 1);

   // Reject configurations the counters and shift logic are not built for.
   if (WORD_WIDTH < 2 || WARMUP_CYCLES < 1 || SAMPLE_DIV < 1 ||
       RC_LIMIT < 2 || RC_LIMIT > WORD_WIDTH) begin : g_param_check
      $error("trng_ctrl: parameter out of range");
   end

   logic                  s_bit;
   logic [1:0]            state_q, state_d;
   logic [WCW-1:0]        warm_q, warm_d;
   logic [DCW-1:0]        div_q, div_d;
   logic [BCW-1:0]        bit_q, bit_d;
   // Holds the first WORD_WIDTH-1 captures; the last capture completes the word.
   logic [WORD_WIDTH-2:0] sr_q, sr_d;
   logic [WORD_WIDTH-1:0] data_q, data_d;
   logic [WORD_WIDTH-1:0] shifted;
   logic                  capture;
   logic                  rc_hit;

   trng_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (trng_in),
      .q     (s_bit)
   );

   assign capture = (state_q == S_SAMPLE) && enable && (div_q == DIV_LAST);
   assign shifted = {sr_q, s_bit};

`ifdef TRNG_HEALTH_EN
   localparam int RCW = $clog2(RC_LIMIT) + 1;
   localparam logic [RCW-1:0] RC_MAX = RCW'(RC_LIMIT);

   logic [RCW-1:0] run_q, run_d;
   logic           last_q, last_d;
   logic           fail_q, fail_d;

   // Repetition-count tracking across captures; saturates so a stuck source
   // keeps discarding until the bit changes.
   always_comb begin
      run_d  = run_q;
      last_d = last_q;
      fail_d = fail_q;
      rc_hit = 1'b0;
      if (state_q == S_IDLE && enable) begin
         run_d  = '0;
         fail_d = 1'b0;
      end else if (capture) begin
         if (run_q != '0 && s_bit == last_q) begin
            run_d = (run_q == RC_MAX) ? run_q : run_q + 1'b1;
         end else begin
            run_d = RCW'(1);
         end
         last_d = s_bit;
         if (run_d == RC_MAX) begin
            rc_hit = 1'b1;
            fail_d = 1'b1;
         end
      end
   end

   // Health-test state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         run_q  <= '0;
         last_q <= 1'b0;
         fail_q <= 1'b0;
      end else begin
         run_q  <= run_d;
         last_q <= last_d;
         fail_q <= fail_d;
      end
   end

   assign health_fail_o = fail_q;
`else
   assign rc_hit        = 1'b0;
   assign health_fail_o = 1'b0;
`endif

   // Sequencing FSM with warm-up, sample divider, bit packing and handshake.
   always_comb begin
      state_d = state_q;
      warm_d  = warm_q;
      div_d   = div_q;
      bit_d   = bit_q;
      sr_d    = sr_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d = S_WARMUP;
               warm_d  = '0;
               div_d   = '0;
               bit_d   = '0;
               sr_d    = '0;
            end
         end
         S_WARMUP: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (warm_q == WARM_LAST) begin
               state_d = S_SAMPLE;
               div_d   = '0;
               bit_d   = '0;
            end else begin
               warm_d = warm_q + 1'b1;
            end
         end
         S_SAMPLE: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (capture) begin
               div_d = '0;
               sr_d  = shifted[WORD_WIDTH-2:0];
               if (rc_hit) begin
                  bit_d = '0;
               end else if (bit_q == BIT_LAST) begin
                  state_d = S_HOLD;
                  data_d  = shifted;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: begin
            if (bus.ready_i) begin
               state_d = enable ? S_SAMPLE : S_IDLE;
               div_d   = '0;
               bit_d   = '0;
            end
         end
      endcase
   end

   // Controller state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         warm_q  <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         sr_q    <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         warm_q  <= warm_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         sr_q    <= sr_d;
         data_q  <= data_d;
      end
   end

   assign trng_en     = (state_q == S_WARMUP) || (state_q == S_SAMPLE) ||
                        ((state_q == S_HOLD) && enable);
   assign busy_o      = (state_q != S_IDLE);
   assign bus.valid_o = (state_q == S_HOLD);
   assign bus.data_o  = data_q;
   assign state_o     = trng_ctrl_state_t'(state_q);
endmodule
